// File: rtl/spi_rom_reader.sv
// spi_rom_reader: SPI mode-0 master that streams bytes from a serial flash
// with the READ (0x03) command and a 24-bit address. It can send a one-shot
// release-from-power-down (0xAB) before the first read after reset.
// SCLK runs at clk/2. Each SPI bit takes two clk cycles. MOSI changes on the
// edge that drives SCLK low. MISO is sampled on the edge that ends the high half.
//
// Handshake: start_i is accepted on a clk edge where busy_o=0. There is no
// backpressure: data_valid_o is a one-cycle strobe and data_out_o holds its
// value between strobes.
module spi_rom_reader #(
   parameter int LEN_W   = 8,
   parameter int WAKE_EN = 1,
   parameter int CSB_GAP = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [23:0]      addr_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic             abort_i,
   output logic             busy_o,
   output logic [7:0]       data_out_o,
   output logic             data_valid_o,
   output logic             done_o,
   output logic             spi_csb_o,
   output logic             spi_sclk_o,
   output logic             spi_mosi_o,
   input  logic             spi_miso_i,
   output logic [2:0]       dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAKE = 3'd1,
      S_GAP  = 3'd2,
      S_CMD  = 3'd3,
      S_DATA = 3'd4,
      S_END  = 3'd5
   } state_t;

   localparam int GAP_W = $clog2(CSB_GAP);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CSB_GAP - 1);

   state_t           state_q;
   logic             woken_q;
   logic             busy_q;
   logic             csb_q;
   logic             sclk_q;
   logic             mosi_q;
   logic [7:0]       data_out_q;
   logic             data_valid_q;
   logic             done_q;
   logic [23:0]      addr_q;
   logic [LEN_W-1:0] rem_q;      // bytes still to fetch after the current one
   logic [4:0]       bit_cnt_q;  // bits left after the current one in this segment
   logic [30:0]      tx_q;       // outgoing bits not yet placed on MOSI
   logic [6:0]       rx_q;       // incoming bits of the byte being assembled
   logic [GAP_W-1:0] gap_cnt_q;
   logic [7:0]       rx_d;

   // Byte as it stands once this edge's MISO sample is shifted in
   assign rx_d = {rx_q, spi_miso_i};

   // Control FSM, SPI bit engine and all registered outputs
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= S_IDLE;
         woken_q      <= 1'b0;
         busy_q       <= 1'b0;
         csb_q        <= 1'b1;
         sclk_q       <= 1'b0;
         mosi_q       <= 1'b0;
         data_out_q   <= 8'h00;
         data_valid_q <= 1'b0;
         done_q       <= 1'b0;
         addr_q       <= 24'h0;
         rem_q        <= '0;
         bit_cnt_q    <= 5'd0;
         tx_q         <= 31'h0;
         rx_q         <= 7'h0;
         gap_cnt_q    <= '0;
      end else begin
         data_valid_q <= 1'b0;
         done_q       <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  busy_q <= 1'b1;
                  csb_q  <= 1'b0;
                  sclk_q <= 1'b0;
                  addr_q <= addr_i;
                  rem_q  <= len_i;
                  if (WAKE_EN != 0 && !woken_q) begin
                     // 0xAB: MSB goes out now, the other seven bits wait in tx_q
                     state_q   <= S_WAKE;
                     mosi_q    <= 1'b1;
                     tx_q      <= {7'h2B, 24'h0};
                     bit_cnt_q <= 5'd7;
                  end else begin
                     // 0x03 then address: MSB of 0x03 is 0
                     state_q   <= S_CMD;
                     mosi_q    <= 1'b0;
                     tx_q      <= {7'h03, addr_i};
                     bit_cnt_q <= 5'd31;
                  end
               end
            end

            S_GAP: begin
               if (abort_i) begin
                  gap_cnt_q <= GAP_LOAD;
                  state_q   <= S_END;
               end else if (gap_cnt_q == '0) begin
                  // The device is only counted as awake once the gap completes
                  woken_q   <= 1'b1;
                  csb_q     <= 1'b0;
                  sclk_q    <= 1'b0;
                  mosi_q    <= 1'b0;
                  tx_q      <= {7'h03, addr_q};
                  bit_cnt_q <= 5'd31;
                  state_q   <= S_CMD;
               end else begin
                  gap_cnt_q <= gap_cnt_q - 1'b1;
               end
            end

            S_END: begin
               if (gap_cnt_q == '0) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q - 1'b1;
               end
            end

            default: begin
               // A byte that completes on this edge is delivered even when abort
               // arrives on the same edge. Only done is held back in that case.
               if (state_q == S_DATA && sclk_q && bit_cnt_q == 5'd0) begin
                  data_out_q   <= rx_d;
                  data_valid_q <= 1'b1;
                  done_q       <= (rem_q == '0) && !abort_i;
               end
               if (abort_i) begin
                  csb_q     <= 1'b1;
                  sclk_q    <= 1'b0;
                  mosi_q    <= 1'b0;
                  gap_cnt_q <= GAP_LOAD;
                  state_q   <= S_END;
               end else if (!sclk_q) begin
                  sclk_q <= 1'b1;
               end else begin
                  // End of the high half: sample MISO, drop SCLK, move to the next bit
                  sclk_q <= 1'b0;
                  rx_q   <= rx_d[6:0];
                  if (bit_cnt_q != 5'd0) begin
                     bit_cnt_q <= bit_cnt_q - 5'd1;
                     mosi_q    <= tx_q[30];
                     tx_q      <= {tx_q[29:0], 1'b0};
                  end else begin
                     case (state_q)
                        S_WAKE: begin
                           csb_q     <= 1'b1;
                           mosi_q    <= 1'b0;
                           gap_cnt_q <= GAP_LOAD;
                           state_q   <= S_GAP;
                        end
                        S_CMD: begin
                           mosi_q    <= 1'b0;
                           bit_cnt_q <= 5'd7;
                           state_q   <= S_DATA;
                        end
                        S_DATA: begin
                           if (rem_q == '0) begin
                              csb_q     <= 1'b1;
                              gap_cnt_q <= GAP_LOAD;
                              state_q   <= S_END;
                           end else begin
                              rem_q     <= rem_q - 1'b1;
                              bit_cnt_q <= 5'd7;
                           end
                        end
                        default: begin
                           csb_q     <= 1'b1;
                           mosi_q    <= 1'b0;
                           gap_cnt_q <= GAP_LOAD;
                           state_q   <= S_END;
                        end
                     endcase
                  end
               end
            end
         endcase
      end
   end

   assign busy_o       = busy_q;
   assign data_out_o   = data_out_q;
   assign data_valid_o = data_valid_q;
   assign done_o       = done_q;
   assign spi_csb_o    = csb_q;
   assign spi_sclk_o   = sclk_q;
   assign spi_mosi_o   = mosi_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_spi_rom_reader.sv
// Bench for spi_rom_reader. It contains a behavioural SPI flash responder, a
// scoreboard of expected bytes with a separate monitor, and a protocol watcher.
module tb_spi_rom_reader;

   localparam int G = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [23:0] addr;
   logic [7:0]  len;
   logic        miso = 1'b0;
   logic        busy;
   logic [7:0]  dout;
   logic        dv;
   logic        done;
   logic        csb;
   logic        sclk;
   logic        mosi;
   logic [2:0]  dbg_state;

   spi_rom_reader #(.LEN_W(8), .WAKE_EN(1), .CSB_GAP(G)) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .start_i      (start),
      .addr_i       (addr),
      .len_i        (len),
      .abort_i      (abort),
      .busy_o       (busy),
      .data_out_o   (dout),
      .data_valid_o (dv),
      .done_o       (done),
      .spi_csb_o    (csb),
      .spi_sclk_o   (sclk),
      .spi_mosi_o   (mosi),
      .spi_miso_i   (miso),
      .dbg_state_o  (dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // flash contents: a fixed function of the address
   function automatic logic [7:0] mem_byte(input logic [23:0] a);
      return (a[7:0] ^ a[23:16] ^ 8'h5A) + {a[14:8], 1'b1};
   endfunction

   // flash responder, logs every CSB-low transaction
   typedef struct {
      logic [7:0]  first;
      logic [23:0] addr;
      int          nbits;
      int          gap;
   } txn_t;
   txn_t        fl_log[$];
   int          fl_bits = 0;
   logic [31:0] fl_sr = '0;
   logic [7:0]  fl_first = '0;
   int          last_gap = 0;

   always @(negedge csb) begin
      fl_bits  = 0;
      fl_sr    = '0;
      fl_first = '0;
   end

   always @(posedge sclk) begin
      if (csb === 1'b0) begin
         if (fl_bits < 32) fl_sr = {fl_sr[30:0], mosi};
         fl_bits++;
         if (fl_bits == 8) fl_first = fl_sr[7:0];
      end
   end

   always @(negedge sclk) begin : fl_drive
      int          b;
      logic [23:0] a;
      logic [7:0]  d;
      if (csb === 1'b0 && fl_bits >= 32 && fl_sr[31:24] == 8'h03) begin
         b = fl_bits - 32;
         a = fl_sr[23:0] + 24'(b / 8);
         d = mem_byte(a);
         miso = d[7 - (b % 8)];
      end
   end

   always @(posedge csb) begin : fl_close
      txn_t t;
      t.first = fl_first;
      t.addr  = fl_sr[23:0];
      t.nbits = fl_bits;
      t.gap   = last_gap;
      fl_log.push_back(t);
   end

   // protocol watcher
   int   hi_run = 1000;
   int   v_gap = 0;
   int   v_sclk = 0;
   int   v_mosi = 0;
   logic prev_csb = 1'b1;
   logic prev_mosi = 1'b0;

   always @(negedge clk) begin
      if (reset !== 1'b0) begin
         hi_run = 1000;
      end else begin
         if (csb === 1'b1) begin
            hi_run++;
            if (sclk !== 1'b0) v_sclk++;
         end else begin
            if (prev_csb === 1'b1) begin
               last_gap = hi_run;
               if (hi_run < G) v_gap++;
            end
            hi_run = 0;
         end
         if (sclk === 1'b1 && mosi !== prev_mosi) v_mosi++;
      end
      prev_csb  = csb;
      prev_mosi = mosi;
   end

   // scoreboard and monitor
   logic [7:0] exp_q[$];
   logic       exp_last_q[$];
   int         n_dv = 0;
   int         n_done = 0;
   int         n_done_exp = 0;
   int         last_dv_cyc = 0;
   int         first_dv_cyc = 0;
   bit         first_pending = 0;
   int         start_cyc = 0;
   int         idle_cyc = 0;

   always @(negedge clk) begin : monitor
      logic [7:0] e;
      logic       l;
      if (reset === 1'b0) begin
         if (dv === 1'b1) begin
            n_dv++;
            last_dv_cyc = cyc;
            if (first_pending) begin
               first_dv_cyc  = cyc;
               first_pending = 0;
            end
            if (exp_q.size() == 0) begin
               check("unexpected_data_valid", 32'(dv), 32'd0);
            end else begin
               e = exp_q.pop_front();
               l = exp_last_q.pop_front();
               check("data_out", 32'(dout), 32'(e));
               check("done_with_last", 32'(done), 32'(l));
            end
         end else if (done === 1'b1) begin
            check("done_without_data", 32'(done), 32'd0);
         end
         if (done === 1'b1) n_done++;
      end
   end

   // driver tasks
   task automatic issue(input logic [23:0] a, input logic [7:0] l, input int n_exp, input bit exp_done);
      logic [23:0] ai;
      @(negedge clk);
      start = 1'b1;
      addr  = a;
      len   = l;
      for (int i = 0; i < n_exp; i++) begin
         ai = a + 24'(i);
         exp_q.push_back(mem_byte(ai));
         exp_last_q.push_back(exp_done && (i == int'(l)));
      end
      if (exp_done) n_done_exp++;
      first_pending = 1;
      @(negedge clk);
      start     = 1'b0;
      start_cyc = cyc;
      addr      = 24'($urandom);
      len       = 8'($urandom);
      check("busy_after_start", 32'(busy), 32'd1);
   endtask

   task automatic wait_idle(input string name, input int maxc);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      idle_cyc = cyc;
      if (busy !== 1'b0) check({name, "_timeout"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // stimulus
   initial begin : main
      int          base;
      int          done_base;
      int          n;
      int          ab_cyc;
      logic [23:0] a;
      logic [7:0]  l;

      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      addr  = '0;
      len   = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_data_out", 32'(dout), 32'd0);
      check("rst_data_valid", 32'(dv), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_csb", 32'(csb), 32'd1);
      check("rst_sclk", 32'(sclk), 32'd0);
      check("rst_mosi", 32'(mosi), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      fl_log.delete();

      // first read after reset: wake, gap, then read
      issue(24'h000010, 8'd3, 4, 1);
      wait_idle("t1", 2000);
      check("t1_first_latency", 32'(first_dv_cyc - start_cyc), 32'(80 + 16 + G));
      check("t1_busy_fall", 32'(idle_cyc - last_dv_cyc), 32'(G));
      check("t1_drained", 32'(exp_q.size()), 32'd0);
      check("t1_txn_count", 32'(fl_log.size()), 32'd2);
      if (fl_log.size() == 2) begin
         check("t1_wake_byte", 32'(fl_log[0].first), 32'h00AB);
         check("t1_wake_bits", 32'(fl_log[0].nbits), 32'd8);
         check("t1_wake_gap", 32'(fl_log[1].gap), 32'(G));
         check("t1_cmd_byte", 32'(fl_log[1].first), 32'h0003);
         check("t1_cmd_addr", 32'(fl_log[1].addr), 32'h000010);
         check("t1_cmd_bits", 32'(fl_log[1].nbits), 32'd64);
      end

      // second read: no wake, single byte
      fl_log.delete();
      issue(24'h0000FF, 8'd0, 1, 1);
      wait_idle("t2", 2000);
      check("t2_first_latency", 32'(first_dv_cyc - start_cyc), 32'd80);
      check("t2_busy_fall", 32'(idle_cyc - last_dv_cyc), 32'(G));
      check("t2_drained", 32'(exp_q.size()), 32'd0);
      check("t2_txn_count", 32'(fl_log.size()), 32'd1);
      if (fl_log.size() == 1) begin
         check("t2_cmd_byte", 32'(fl_log[0].first), 32'h0003);
         check("t2_cmd_addr", 32'(fl_log[0].addr), 32'h0000FF);
      end

      // address wrap across the top of the device
      issue(24'hFFFFFE, 8'd3, 4, 1);
      wait_idle("t3", 2000);
      check("t3_drained", 32'(exp_q.size()), 32'd0);

      // abort in the middle of byte 2 of an 8-byte burst
      base      = n_dv;
      done_base = n_done;
      issue(24'h000400, 8'd7, 2, 0);
      n = 0;
      while (n_dv < base + 2 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("t4_bytes_before_abort", 32'(n_dv - base), 32'd2);
      repeat (5) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort  = 1'b0;
      ab_cyc = cyc;
      check("t4_csb_after_abort", 32'(csb), 32'd1);
      check("t4_sclk_after_abort", 32'(sclk), 32'd0);
      check("t4_busy_in_gap", 32'(busy), 32'd1);
      wait_idle("t4", 500);
      check("t4_busy_fall", 32'(idle_cyc - ab_cyc), 32'(G));
      check("t4_strobe_count", 32'(n_dv - base), 32'd2);
      check("t4_no_done", 32'(n_done - done_base), 32'd0);
      check("t4_drained", 32'(exp_q.size()), 32'd0);
      issue(24'h000800, 8'd2, 3, 1);
      wait_idle("t4b", 2000);
      check("t4b_drained", 32'(exp_q.size()), 32'd0);

      // start while busy is ignored
      fl_log.delete();
      issue(24'h123456, 8'd1, 2, 1);
      repeat (20) @(negedge clk);
      start = 1'b1;
      addr  = 24'h000000;
      len   = 8'd5;
      @(negedge clk);
      start = 1'b0;
      wait_idle("t5", 2000);
      check("t5_drained", 32'(exp_q.size()), 32'd0);
      check("t5_txn_count", 32'(fl_log.size()), 32'd1);
      if (fl_log.size() == 1) check("t5_addr_kept", 32'(fl_log[0].addr), 32'h123456);

      // asynchronous reset in the middle of the command phase
      issue(24'h000200, 8'd3, 0, 0);
      repeat (30) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("t5_rst_csb", 32'(csb), 32'd1);
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_sclk", 32'(sclk), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      exp_last_q.delete();
      @(negedge clk);
      fl_log.delete();
      issue(24'h000020, 8'd1, 2, 1);
      wait_idle("t5r", 2000);
      check("t5r_drained", 32'(exp_q.size()), 32'd0);
      check("t5r_txn_count", 32'(fl_log.size()), 32'd2);
      if (fl_log.size() == 2) begin
         check("t5r_wake_byte", 32'(fl_log[0].first), 32'h00AB);
         check("t5r_cmd_addr", 32'(fl_log[1].addr), 32'h000020);
      end

      // random bursts, some near the top of the address space
      for (int k = 0; k < 12; k++) begin
         if ($urandom_range(0, 3) == 0) a = 24'hFFFFF0 + 24'($urandom_range(0, 15));
         else a = 24'($urandom);
         l = 8'($urandom_range(0, 15));
         issue(a, l, int'(l) + 1, 1);
         wait_idle("rand", 2000);
         check("rand_drained", 32'(exp_q.size()), 32'd0);
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end

      // maximum length, crossing the wrap point
      issue(24'hFFFF80, 8'hFF, 256, 1);
      wait_idle("full", 6000);
      check("full_drained", 32'(exp_q.size()), 32'd0);

      // final report
      check("done_count", 32'(n_done), 32'(n_done_exp));
      check("proto_csb_gap", 32'(v_gap), 32'd0);
      check("proto_sclk_idle", 32'(v_sclk), 32'd0);
      check("proto_mosi_stable", 32'(v_mosi), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
